// File: rtl/fifo_mc_pkg.sv
// fifo_mc shared constants, channel flag bundle and width helper.
// Sticky error logic is built only when FIFO_MC_ERR_EN is defined.
package fifo_mc_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_NUM_CH     = 4;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } ch_flags_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mc_if.sv
// fifo_mc bus: write/read requests, read data and per-channel status.
// Error outputs are constant 0 unless FIFO_MC_ERR_EN is defined.
interface fifo_mc_if
  import fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_CH     = DEF_NUM_CH
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic                    w_en;
  logic [CH_W-1:0]         w_ch;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    r_en;
  logic [CH_W-1:0]         r_ch;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_valid;
  logic [NUM_CH-1:0]       full;
  logic [NUM_CH-1:0]       almost_full;
  logic [NUM_CH-1:0]       empty;
  logic [NUM_CH-1:0]       almost_empty;
  logic [NUM_CH*CNT_W-1:0] count;
  logic                    err_clr;
  logic [NUM_CH-1:0]       overflow;
  logic [NUM_CH-1:0]       underflow;

  modport master (
    output w_en, w_ch, w_data,
    output r_en, r_ch, err_clr,
    input  r_data, r_valid,
    input  full, almost_full,
    input  empty, almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  w_en, w_ch, w_data,
    input  r_en, r_ch, err_clr,
    output r_data, r_valid,
    output full, almost_full,
    output empty, almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mc_chan_ctrl.sv
// One channel: wrap-bit pointers, accept logic, flags, sticky errors.
// Sticky errors exist only when FIFO_MC_ERR_EN is defined.
module fifo_mc_chan_ctrl
  import fifo_mc_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int CNT_W    = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              err_clr_i,
  output logic              w_acc_o,
  output logic              r_acc_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [ADDR_W-1:0] raddr_o,
  output logic [CNT_W-1:0]  count_o,
  output ch_flags_t         flags_o,
  output logic              ovf_o,
  output logic              unf_o
);
  localparam logic [CNT_W-1:0] FULL_L = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_L   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_L   = CNT_W'(AE_LEVEL);

  logic [CNT_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] rptr_q, rptr_d;

  assign count_o = wptr_q - rptr_q;
  assign flags_o = '{
    full:   count_o == FULL_L,
    afull:  count_o >= AF_L,
    empty:  count_o == '0,
    aempty: count_o <= AE_L
  };

  // A full channel still takes a write when it is being drained this cycle.
  assign r_acc_o = re_i && !flags_o.empty;
  assign w_acc_o = we_i && (!flags_o.full || r_acc_o);
  assign waddr_o = wptr_q[ADDR_W-1:0];
  assign raddr_o = rptr_q[ADDR_W-1:0];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (w_acc_o) wptr_d = wptr_q + CNT_W'(1);
    if (r_acc_o) rptr_d = rptr_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

`ifdef FIFO_MC_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q & ~err_clr_i;
    unf_d = unf_q & ~err_clr_i;
    if (we_i && !w_acc_o) ovf_d = 1'b1;
    if (re_i && !r_acc_o) unf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`else
  logic unused_clr;
  assign unused_clr = err_clr_i;
  assign ovf_o = 1'b0;
  assign unf_o = 1'b0;
`endif
endmodule

// File: rtl/fifo_mc.sv
// Multi-channel FIFO top: shared storage, read data register, r_valid.
// Optional sticky overflow/underflow enabled by FIFO_MC_ERR_EN.
module fifo_mc
  import fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic      clk,
  input logic      rst_n,
  fifo_mc_if.slave bus
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam int MA_W   = CH_W + ADDR_W;

  logic [DATA_WIDTH-1:0] mem_q [NUM_CH*DEPTH];

  logic [NUM_CH-1:0] w_acc, r_acc;
  logic [NUM_CH-1:0] full_v, af_v, em_v, ae_v;
  logic [NUM_CH-1:0] ovf_v, unf_v;
  logic [NUM_CH-1:0][ADDR_W-1:0] waddr_v, raddr_v;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_v;
  ch_flags_t flags_v [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_mc_chan_ctrl #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
    ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (bus.w_en && (bus.w_ch == CH_W'(c))),
      .re_i      (bus.r_en && (bus.r_ch == CH_W'(c))),
      .err_clr_i (bus.err_clr),
      .w_acc_o   (w_acc[c]),
      .r_acc_o   (r_acc[c]),
      .waddr_o   (waddr_v[c]),
      .raddr_o   (raddr_v[c]),
      .count_o   (cnt_v[c]),
      .flags_o   (flags_v[c]),
      .ovf_o     (ovf_v[c]),
      .unf_o     (unf_v[c])
    );
    assign full_v[c] = flags_v[c].full;
    assign af_v[c]   = flags_v[c].afull;
    assign em_v[c]   = flags_v[c].empty;
    assign ae_v[c]   = flags_v[c].aempty;
  end

  logic [MA_W-1:0] wa, ra;
  assign wa = {bus.w_ch, waddr_v[bus.w_ch]};
  assign ra = {bus.r_ch, raddr_v[bus.r_ch]};

  always_ff @(posedge clk) begin
    if (|w_acc) mem_q[wa] <= bus.w_data;
  end

  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;

  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = |r_acc;
    if (|r_acc) r_data_d = mem_q[ra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign bus.r_data       = r_data_q;
  assign bus.r_valid      = r_valid_q;
  assign bus.full         = full_v;
  assign bus.almost_full  = af_v;
  assign bus.empty        = em_v;
  assign bus.almost_empty = ae_v;
  assign bus.count        = cnt_v;
  assign bus.overflow     = ovf_v;
  assign bus.underflow    = unf_v;
endmodule

// File: tb/tb_fifo_mc.sv
// Bench for fifo_mc: vector table, corner sequences, random vs queues.
// Error flag expectations follow FIFO_MC_ERR_EN.
module tb_fifo_mc;
  import fifo_mc_pkg::*;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int NCH = 4;
  localparam int CW  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_mc_if #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .NUM_CH     (NCH)
  ) bus ();

  fifo_mc #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEP),
    .NUM_CH     (NCH),
    .AF_LEVEL   (DEP - 2),
    .AE_LEVEL   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0]  mq [NCH][$];
  logic           m_rv;
  logic [DW-1:0]  m_rd;
  logic [NCH-1:0] m_ovf, m_unf;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string nm,
                       input logic [63:0] a,
                       input logic [63:0] e);
    tot_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, a, e);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_rv  = 1'b0;
    m_rd  = '0;
    m_ovf = '0;
    m_unf = '0;
  endtask

  task automatic check_state(input string tag);
    logic [NCH-1:0] ef, eaf, ee, eae, eo, eu;
    logic [NCH*CW-1:0] ec;
    for (int c = 0; c < NCH; c++) begin
      int n;
      n = mq[c].size();
      ef[c]  = (n == DEP);
      eaf[c] = (n >= DEP - 2);
      ee[c]  = (n == 0);
      eae[c] = (n <= 2);
      ec[c*CW +: CW] = CW'(n);
    end
`ifdef FIFO_MC_ERR_EN
    eo = m_ovf;
    eu = m_unf;
`else
    eo = '0;
    eu = '0;
`endif
    check({tag, ".r_valid"}, 64'(bus.r_valid), 64'(m_rv));
    check({tag, ".r_data"}, 64'(bus.r_data), 64'(m_rd));
    check({tag, ".count"}, 64'(bus.count), 64'(ec));
    check({tag, ".full"}, 64'(bus.full), 64'(ef));
    check({tag, ".afull"}, 64'(bus.almost_full), 64'(eaf));
    check({tag, ".empty"}, 64'(bus.empty), 64'(ee));
    check({tag, ".aempty"}, 64'(bus.almost_empty), 64'(eae));
    check({tag, ".ovf"}, 64'(bus.overflow), 64'(eo));
    check({tag, ".unf"}, 64'(bus.underflow), 64'(eu));
  endtask

  task automatic cyc(input logic we, input logic [1:0] wc,
                     input logic [DW-1:0] wd,
                     input logic re, input logic [1:0] rc,
                     input logic clr, input string tag);
    logic racc, wacc;
    bus.w_en = we;
    bus.w_ch = wc;
    bus.w_data = wd;
    bus.r_en = re;
    bus.r_ch = rc;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    racc = re && (mq[rc].size() > 0);
    wacc = we && ((mq[wc].size() < DEP) || (racc && rc == wc));
    if (clr) begin
      m_ovf = '0;
      m_unf = '0;
    end
    if (re && !racc) m_unf[rc] = 1'b1;
    if (we && !wacc) m_ovf[wc] = 1'b1;
    m_rv = racc;
    if (racc) m_rd = mq[rc].pop_front();
    if (wacc) mq[wc].push_back(wd);
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    bus.err_clr = 1'b0;
    check_state(tag);
  endtask

  typedef struct {
    logic          we;
    logic [1:0]    wc;
    logic [31:0]   wd;
    logic          re;
    logic [1:0]    rc;
    logic          clr;
    logic          erv;
    logic [31:0]   erd;
    logic [3:0]    eempty;
    logic [19:0]   ecnt;
  } vec_t;

  vec_t vt [10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1, 0, 32'h55, 1, 0, 0, 0, 32'h00, 4'b1110, 20'h00001};
    vt[1] = '{0, 0, 32'h00, 1, 0, 0, 1, 32'h55, 4'b1111, 20'h00000};
    vt[2] = '{1, 1, 32'h11, 0, 0, 0, 0, 32'h55, 4'b1101, 20'h00020};
    vt[3] = '{1, 1, 32'h12, 0, 0, 0, 0, 32'h55, 4'b1101, 20'h00040};
    vt[4] = '{1, 3, 32'h33, 1, 1, 0, 1, 32'h11, 4'b0101, 20'h08020};
    vt[5] = '{1, 1, 32'h13, 1, 1, 0, 1, 32'h12, 4'b0101, 20'h08020};
    vt[6] = '{0, 0, 32'h00, 1, 3, 0, 1, 32'h33, 4'b1101, 20'h00020};
    vt[7] = '{0, 0, 32'h00, 1, 1, 0, 1, 32'h13, 4'b1111, 20'h00000};
    vt[8] = '{0, 0, 32'h00, 1, 2, 0, 0, 32'h13, 4'b1111, 20'h00000};
    vt[9] = '{0, 0, 32'h00, 0, 0, 1, 0, 32'h13, 4'b1111, 20'h00000};

    bus.w_en = 0;
    bus.w_ch = 0;
    bus.w_data = 0;
    bus.r_en = 0;
    bus.r_ch = 0;
    bus.err_clr = 0;
    model_reset();
    #12;
    check("rst.empty", 64'(bus.empty), 64'hF);
    check("rst.aempty", 64'(bus.almost_empty), 64'hF);
    check_state("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      cyc(vt[i].we, vt[i].wc, vt[i].wd,
          vt[i].re, vt[i].rc, vt[i].clr, t);
      check({t, ".t_rv"}, 64'(bus.r_valid), 64'(vt[i].erv));
      check({t, ".t_rd"}, 64'(bus.r_data), 64'(vt[i].erd));
      check({t, ".t_em"}, 64'(bus.empty), 64'(vt[i].eempty));
      check({t, ".t_cnt"}, 64'(bus.count), 64'(vt[i].ecnt));
    end

    for (int i = 0; i < DEP; i++) begin
      cyc(1, 2, 32'h200 + i, 0, 0, 0, "fill2");
      check($sformatf("af2_w%0d", i + 1),
            64'(bus.almost_full[2]), 64'(i >= DEP - 3));
    end
    check("full2", 64'(bus.full[2]), 64'h1);
    check("cnt2", 64'(bus.count[2*CW +: CW]), 64'd16);
    cyc(1, 2, 32'hBAD, 0, 0, 0, "ovf2");
    for (int i = 0; i < DEP; i++) begin
      cyc(0, 0, 0, 1, 2, 0, "drain2");
      check("drain2_rv", 64'(bus.r_valid), 64'h1);
      check("drain2_rd", 64'(bus.r_data), 64'h200 + 64'(i));
    end
    cyc(0, 0, 0, 0, 0, 1, "idle2");

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'hA0 + i, 0, 0, 0, "il_w0");
      cyc(1, 3, 32'hB0 + i, 0, 0, 0, "il_w3");
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 0, 0, "il_r0");
      check("il_rd0", 64'(bus.r_data), 64'hA0 + 64'(i));
      cyc(0, 0, 0, 1, 3, 0, "il_r3");
      check("il_rd3", 64'(bus.r_data), 64'hB0 + 64'(i));
    end

    for (int i = 0; i < DEP; i++)
      cyc(1, 1, 32'h100 + i, 0, 0, 0, "fill1");
    cyc(1, 1, 32'hDEAD, 1, 1, 0, "rw1");
    check("rw1_cnt", 64'(bus.count[CW +: CW]), 64'd16);
    check("rw1_rd", 64'(bus.r_data), 64'h100);
    for (int i = 0; i < DEP; i++)
      cyc(0, 0, 0, 1, 1, 0, "drain1");
    check("dead_last", 64'(bus.r_data), 64'hDEAD);

    for (int i = 0; i < 7; i++)
      cyc(1, 3, 32'h300 + i, 0, 0, 0, "fill3");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.cnt3", 64'(bus.count[3*CW +: CW]), 64'd0);
    check("arst.empty", 64'(bus.empty), 64'hF);
    check_state("arst");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 3, 0, "arst_r3");

    for (int i = 0; i < 1500; i++) begin
      logic we, re, clr;
      logic [1:0] wc, rc;
      we  = ($urandom_range(0, 99) < 60);
      re  = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 31) == 0);
      wc  = 2'($urandom_range(0, 3));
      rc  = 2'($urandom_range(0, 3));
      cyc(we, wc, $urandom, re, rc, clr, "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
